// File: rtl/xor_decrypt_rx.sv
// xor_decrypt_rx: receive-side XOR decryptor.
// Deserializes a KEY_SIZE-bit key and a MSG_SIZE-bit ciphertext from the shared
// serial pin iData_in (MSB first), each qualified by its own flag. It XORs every
// KEY_SIZE-bit chunk of the ciphertext with the key, one chunk per cycle with the
// MSB chunk first, and then streams the plaintext out MSB first on oPlain_out/oPlain_flag.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   ena           clock enable; when low, all state and outputs hold
//   iData_in      shared serial data
//   iKey_flag     iData_in carries a key bit (this flag wins over iCipher_flag)
//   iCipher_flag  iData_in carries a ciphertext bit
//   oPlain_out    serial plaintext bit
//   oPlain_flag   oPlain_out is valid
//   oBusy         high while decrypting or sending
//   oDone         one-cycle pulse after the last plaintext bit
//   oError        one-cycle pulse when a ciphertext load is aborted
//
// Optional feature: when XOR_RX_KEY_CLEAR_EN is defined, the key and its counter
// clear on the oDone cycle (one-time-key mode). When it is undefined, the key
// persists until reset.
module xor_decrypt_rx #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic iData_in,
    input  logic iKey_flag,
    input  logic iCipher_flag,
    output logic oPlain_out,
    output logic oPlain_flag,
    output logic oBusy,
    output logic oDone,
    output logic oError
);
    localparam int NCHUNK = MSG_SIZE / KEY_SIZE;
    localparam int KCW    = $clog2(KEY_SIZE + 1);
    localparam int MCW    = $clog2(MSG_SIZE + 1);
    localparam int CCW    = $clog2(NCHUNK + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_KEY = 3'd2,
        S_DECRYPT  = 3'd3,
        S_SEND     = 3'd4
    } state_t;

    // XOR the key into chunk idx (idx 0 is the most significant chunk).
    function automatic logic [MSG_SIZE-1:0] xor_chunk(
        input logic [MSG_SIZE-1:0] msg,
        input logic [KEY_SIZE-1:0] key,
        input logic [CCW-1:0]      idx
    );
        logic [MSG_SIZE-1:0] mask;
        mask = MSG_SIZE'(key) << ((NCHUNK - 1 - int'(idx)) * KEY_SIZE);
        return msg ^ mask;
    endfunction

    state_t               state_q, state_d;
    logic [KEY_SIZE-1:0]  key_q, key_d;
    logic [KCW-1:0]       key_cnt_q, key_cnt_d;
    logic [KEY_SIZE-1:0]  key_snap_q, key_snap_d;
    logic [MSG_SIZE-1:0]  msg_q, msg_d;
    logic [MCW-1:0]       cnt_q, cnt_d;
    logic [CCW-1:0]       chunk_q, chunk_d;
    logic [MCW-1:0]       send_cnt_q, send_cnt_d;
    logic                 plain_out_q, plain_out_d;
    logic                 plain_flag_q, plain_flag_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic key_full_s;
    logic cipher_bit_s;
    logic last_cipher_s;
    logic send_end_s;

    assign key_full_s    = (key_cnt_q == KCW'(KEY_SIZE));
    // A simultaneous key bit takes the pin, so the ciphertext does not advance.
    assign cipher_bit_s  = iCipher_flag & ~iKey_flag;
    assign last_cipher_s = cipher_bit_s & (cnt_q == MCW'(MSG_SIZE - 1));
    assign send_end_s    = (send_cnt_q == MCW'(MSG_SIZE));

    // Key shift register and saturating key counter.
    always_comb begin
        key_d     = key_q;
        key_cnt_d = key_cnt_q;
`ifdef XOR_RX_KEY_CLEAR_EN
        if ((state_q == S_SEND) && send_end_s) begin
            key_d     = {KEY_SIZE{1'b0}};
            key_cnt_d = {KCW{1'b0}};
        end else
`endif
        if (iKey_flag && !key_full_s) begin
            key_d     = (key_q << 1) | KEY_SIZE'(iData_in);
            key_cnt_d = key_cnt_q + KCW'(1);
        end else begin
            key_d     = key_q;
            key_cnt_d = key_cnt_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cipher_bit_s) state_d = S_LOAD;
                else              state_d = S_IDLE;
            end
            S_LOAD: begin
                if (!iCipher_flag)      state_d = S_IDLE;
                else if (last_cipher_s) state_d = key_full_s ? S_DECRYPT : S_WAIT_KEY;
                else                    state_d = S_LOAD;
            end
            S_WAIT_KEY: begin
                if (key_full_s) state_d = S_DECRYPT;
                else            state_d = S_WAIT_KEY;
            end
            S_DECRYPT: begin
                if (chunk_q == CCW'(NCHUNK - 1)) state_d = S_SEND;
                else                             state_d = S_DECRYPT;
            end
            S_SEND: begin
                if (send_end_s) state_d = S_IDLE;
                else            state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic.
    always_comb begin
        msg_d        = msg_q;
        cnt_d        = cnt_q;
        chunk_d      = chunk_q;
        send_cnt_d   = send_cnt_q;
        key_snap_d   = key_snap_q;
        plain_out_d  = plain_out_q;
        plain_flag_d = plain_flag_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        busy_d       = (state_d == S_DECRYPT) || (state_d == S_SEND);
        case (state_q)
            S_IDLE: begin
                if (cipher_bit_s) begin
                    msg_d = {msg_q[MSG_SIZE-2:0], iData_in};
                    cnt_d = MCW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_LOAD: begin
                if (!iCipher_flag) begin
                    error_d = 1'b1;
                    cnt_d   = {MCW{1'b0}};
                end else if (cipher_bit_s) begin
                    msg_d = {msg_q[MSG_SIZE-2:0], iData_in};
                    cnt_d = cnt_q + MCW'(1);
                    // Latch the key now so later key traffic cannot disturb decryption.
                    if (last_cipher_s && key_full_s) begin
                        key_snap_d = key_q;
                        chunk_d    = {CCW{1'b0}};
                    end else begin
                        key_snap_d = key_snap_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT_KEY: begin
                if (key_full_s) begin
                    key_snap_d = key_q;
                    chunk_d    = {CCW{1'b0}};
                end else begin
                    key_snap_d = key_snap_q;
                end
            end
            S_DECRYPT: begin
                msg_d   = xor_chunk(msg_q, key_snap_q, chunk_q);
                chunk_d = chunk_q + CCW'(1);
                // The first plaintext bit is presented on the final decrypt edge.
                if (chunk_q == CCW'(NCHUNK - 1)) begin
                    plain_flag_d = 1'b1;
                    plain_out_d  = msg_d[MSG_SIZE-1];
                    send_cnt_d   = MCW'(1);
                end else begin
                    plain_flag_d = plain_flag_q;
                end
            end
            S_SEND: begin
                if (send_end_s) begin
                    plain_flag_d = 1'b0;
                    plain_out_d  = 1'b0;
                    done_d       = 1'b1;
                    cnt_d        = {MCW{1'b0}};
                    send_cnt_d   = {MCW{1'b0}};
                end else begin
                    msg_d       = msg_q << 1;
                    plain_out_d = msg_q[MSG_SIZE-2];
                    send_cnt_d  = send_cnt_q + MCW'(1);
                end
            end
            default: begin
                plain_flag_d = 1'b0;
                plain_out_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q        <= {KEY_SIZE{1'b0}};
            key_cnt_q    <= {KCW{1'b0}};
            key_snap_q   <= {KEY_SIZE{1'b0}};
            msg_q        <= {MSG_SIZE{1'b0}};
            cnt_q        <= {MCW{1'b0}};
            chunk_q      <= {CCW{1'b0}};
            send_cnt_q   <= {MCW{1'b0}};
            plain_out_q  <= 1'b0;
            plain_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else if (ena) begin
            key_q        <= key_d;
            key_cnt_q    <= key_cnt_d;
            key_snap_q   <= key_snap_d;
            msg_q        <= msg_d;
            cnt_q        <= cnt_d;
            chunk_q      <= chunk_d;
            send_cnt_q   <= send_cnt_d;
            plain_out_q  <= plain_out_d;
            plain_flag_q <= plain_flag_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign oPlain_out  = plain_out_q;
    assign oPlain_flag = plain_flag_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oError      = error_q;
endmodule

// File: doc/xor_decrypt_rx.md
# xor_decrypt_rx

Receive-side counterpart of the XOR encryption datapath. It deserializes an 8-bit key and a 64-bit ciphertext from a shared serial data pin, each gated by its own load flag. It XOR-decrypts the ciphertext byte-by-byte with the repeating key and re-serializes the plaintext on a data/flag pair. It sits at the far end of the ciphertext serial link (data + flag) and lets a board recover the plaintext.

## Interface
- MSG_SIZE, 64, ciphertext/plaintext width in bits; must be a multiple of KEY_SIZE.
- KEY_SIZE, 8, key width in bits; the key is applied repeatedly to each KEY_SIZE-bit chunk.

- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  when low, all state, counters and outputs hold.
- iData_in  input  1  shared serial data, MSB first.
- iKey_flag  input  1  high: iData_in is a key bit.
- iCipher_flag  input  1  high: iData_in is a ciphertext bit.
- oPlain_out  output  1  serial plaintext, MSB first.
- oPlain_flag  output  1  high while oPlain_out carries a valid bit.
- oBusy  output  1  high in DECRYPT and SEND.
- oDone  output  1  one-cycle pulse after the last plaintext bit.
- oError  output  1  one-cycle pulse on an aborted ciphertext load.

## Operation
- All outputs are registered. Reset value of every output and internal register is 0. The FSM resets to IDLE.
- **Key load** (any state, ena=1, iKey_flag=1):
  - Shift iData_in into the key register MSB first.
  - The key counter increments and saturates at KEY_SIZE.
  - Bits arriving after saturation are ignored.
- **Flag priority:** iKey_flag and iCipher_flag high in the same cycle → the bit goes to the key; the ciphertext counter does not move.
- **FSM states:** IDLE, LOAD, WAIT_KEY, DECRYPT, SEND.
- **IDLE:**
  - iCipher_flag=1 shifts in the first ciphertext bit; count becomes 1; go to LOAD.
- **LOAD:**
  - Each cycle with iCipher_flag=1 shifts in one bit.
  - When the count reaches MSG_SIZE: go to DECRYPT if the key counter equals KEY_SIZE, else go to WAIT_KEY.
  - iCipher_flag low while 0<count<MSG_SIZE: pulse oError, clear the ciphertext counter, go to IDLE. The partial data is discarded.
- **WAIT_KEY:**
  - Ciphertext flags are ignored.
  - When the key counter reaches KEY_SIZE, go to DECRYPT on the next edge.
- **DECRYPT:**
  - One chunk per cycle, MSB chunk first: chunk j ← chunk j XOR key.
  - Runs MSG_SIZE/KEY_SIZE cycles (8 at default), then goes to SEND.
  - The arithmetic is pure bitwise XOR; no carries or widths change.
- **SEND:**
  - oPlain_flag=1 for exactly MSG_SIZE consecutive enabled cycles, one bit per cycle, MSB first.
  - Then oPlain_flag=0, oDone pulses for 1 cycle, the ciphertext counter clears, and the FSM returns to IDLE.
- **Busy handling:** iCipher_flag during WAIT_KEY, DECRYPT or SEND is ignored. Key loading stays legal but must not alter a decrypt already in progress; DECRYPT uses the key snapshot latched on entry.
- **ena=0:** freezes the FSM, counters, shift registers and outputs. A SEND stalled by ena keeps oPlain_flag at its held value.
- **Reset mid-operation:** everything returns to 0/IDLE immediately (asynchronously), including the key.

## Timing
- Edge E0 samples the final ciphertext bit with the key already full.
  - E1..E8: DECRYPT.
  - After E8: oPlain_flag=1 and oPlain_out = plaintext[MSB].
  - Bit k is valid after edge E8+k.
  - After E72: oPlain_flag=0 and oDone=1.
  - After E73: oDone=0.
- oError rises on the edge that samples iCipher_flag=0 during LOAD and lasts 1 cycle.
- oBusy is high from the edge entering DECRYPT through the last SEND cycle.
- oDone and oError never assert in the same cycle.

## Configuration
- **XOR_RX_KEY_CLEAR_EN** defined: one-time-key mode. On the oDone cycle the key register and key counter clear to 0, so the next message waits in WAIT_KEY until a fresh KEY_SIZE-bit key is loaded.
- Undefined: the key and its counter persist across messages until reset; KEY_SIZE further key bits are ignored while saturated.

## Test plan
- Key 0xAC loaded, then ciphertext 0x0123456789ABCDEF → 8 busy cycles, then 64-bit serial 0xAD8FE9CB25076143 with oPlain_flag high for exactly 64 cycles, then a 1-cycle oDone.
- Key 0x00, ciphertext 0xDEADBEEFCAFEF00D → output 0xDEADBEEFCAFEF00D. Round-trip with the encryptor using key 0x5A and plaintext 0x1122334455667788 → the original plaintext.
- Ciphertext loaded first, then key 0xAC → FSM holds in WAIT_KEY with no output, then the output matches case 1. Repeat with both flags high on 4 cycles → those bits go to the key only.
- iCipher_flag dropped after 20 bits → oError 1-cycle pulse, no oPlain_flag. A following full 64-bit load decrypts correctly.
- rst_n asserted at SEND bit 30 → all outputs 0 immediately. After release, a new message needs a new key (key counter = 0).
- With XOR_RX_KEY_CLEAR_EN: two back-to-back messages with one key → the second waits in WAIT_KEY until rekeyed. Without the macro → the second decrypts with the retained key.
